// File: rtl/pipe_pkg.sv
// Shared definitions for the MIPS pipeline: control bundle layout and the
// ID/EX register image.
package pipe_pkg;

  localparam int CTRL_W = 10;

  localparam int REG_WRITE  = 0;
  localparam int MEM_READ   = 1;
  localparam int MEM_WRITE  = 2;
  localparam int MEM_TO_REG = 3;
  localparam int ALU_SRC    = 4;
  localparam int REG_DST    = 5;
  localparam int BRANCH     = 6;
  localparam int ALU_OP     = 7;
  localparam int ALU_OP_W   = 3;

  localparam logic [4:0] ZERO_REG = 5'd0;

  typedef struct packed {
    logic [CTRL_W-1:0] ctrl;
    logic              valid;
    logic [31:0]       a;
    logic [31:0]       b;
    logic [31:0]       imm;
    logic [4:0]        rs;
    logic [4:0]        rt;
    logic [4:0]        rd;
    logic [31:0]       pc4;
  } ex_regs_t;

  function automatic logic [31:0] sign_ext16(input logic [15:0] v);
    return {{16{v[15]}}, v};
  endfunction

endpackage

// File: rtl/hazard_detect.sv
// Load-use compare between the load sitting in EX and the source registers
// of the instruction in ID.
module hazard_detect
  import pipe_pkg::*;
(
  input  logic       ex_valid,
  input  logic       ex_mem_read,
  input  logic [4:0] ex_rt,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  output logic       lu
);

  // rt is compared for every opcode, even when it is not a source operand.
  assign lu = ex_valid & ex_mem_read & (ex_rt != ZERO_REG) &
              ((ex_rt == id_rs) | (ex_rt == id_rt));

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion, flush squashing,
// back-end freeze and a saturating bubble counter.
module id_ex_stage
  import pipe_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       if_id_instr,
  input  logic [31:0]       if_id_pc4,
  input  logic [CTRL_W-1:0] ctrl_in,
  input  logic [31:0]       rd1,
  input  logic [31:0]       rd2,
  input  logic              flush,
  input  logic              ex_stall,
  output logic [CTRL_W-1:0] ex_ctrl,
  output logic              ex_valid,
  output logic [31:0]       ex_a,
  output logic [31:0]       ex_b,
  output logic [31:0]       ex_imm,
  output logic [4:0]        ex_rs,
  output logic [4:0]        ex_rt,
  output logic [4:0]        ex_rd,
  output logic [31:0]       ex_pc4,
  output logic              hazard_stall,
  output logic [31:0]       bubble_count
);

  ex_regs_t    ex_q, ex_d;
  logic [31:0] bubble_count_q, bubble_count_d;
  logic        lu;
  logic        unused_opcode;

  assign unused_opcode = ^if_id_instr[31:26];

  hazard_detect u_hazard_detect (
    .ex_valid    (ex_q.valid),
    .ex_mem_read (ex_q.ctrl[MEM_READ]),
    .ex_rt       (ex_q.rt),
    .id_rs       (if_id_instr[25:21]),
    .id_rt       (if_id_instr[20:16]),
    .lu          (lu)
  );

  assign hazard_stall = lu & ~flush & ~ex_stall;

  // Freeze wins over squash; a bubble is an all-zero image so it can never write.
  always_comb begin
    ex_d           = ex_q;
    bubble_count_d = bubble_count_q;
    if (!ex_stall) begin
      if (flush || lu) begin
        ex_d = '0;
        if (bubble_count_q != 32'hFFFF_FFFF) begin
          bubble_count_d = bubble_count_q + 32'd1;
        end
      end else begin
        ex_d.ctrl  = ctrl_in;
        ex_d.valid = 1'b1;
        ex_d.a     = rd1;
        ex_d.b     = rd2;
        ex_d.imm   = sign_ext16(if_id_instr[15:0]);
        ex_d.rs    = if_id_instr[25:21];
        ex_d.rt    = if_id_instr[20:16];
        ex_d.rd    = if_id_instr[15:11];
        ex_d.pc4   = if_id_pc4;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ex_q           <= '0;
      bubble_count_q <= '0;
    end else begin
      ex_q           <= ex_d;
      bubble_count_q <= bubble_count_d;
    end
  end

  assign ex_ctrl      = ex_q.ctrl;
  assign ex_valid     = ex_q.valid;
  assign ex_a         = ex_q.a;
  assign ex_b         = ex_q.b;
  assign ex_imm       = ex_q.imm;
  assign ex_rs        = ex_q.rs;
  assign ex_rt        = ex_q.rt;
  assign ex_rd        = ex_q.rd;
  assign ex_pc4       = ex_q.pc4;
  assign bubble_count = bubble_count_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Randomized bench for id_ex_stage, checked against a behavioural model of the
// EX stage, with directed scenarios for hazards, flushes, freezes and saturation.
module tb_id_ex_stage;
  import pipe_pkg::*;

  logic              clk = 1'b0;
  logic              reset;
  logic [31:0]       if_id_instr, if_id_pc4, rd1, rd2;
  logic [CTRL_W-1:0] ctrl_in;
  logic              flush, ex_stall;
  logic [CTRL_W-1:0] ex_ctrl;
  logic              ex_valid, hazard_stall;
  logic [31:0]       ex_a, ex_b, ex_imm, ex_pc4, bubble_count;
  logic [4:0]        ex_rs, ex_rt, ex_rd;

  // Reference model state
  logic [CTRL_W-1:0] m_ctrl;
  logic              m_valid;
  logic [31:0]       m_a, m_b, m_imm, m_pc4;
  logic [4:0]        m_rs, m_rt, m_rd;
  longint unsigned   m_count;

  int tests_run    = 0;
  int tests_failed = 0;

  localparam logic [CTRL_W-1:0] CTRL_LW  = CTRL_W'((1 << MEM_READ) | (1 << REG_WRITE) |
                                                    (1 << ALU_SRC) | (1 << MEM_TO_REG));
  localparam logic [CTRL_W-1:0] CTRL_ADD = CTRL_W'((1 << REG_WRITE) | (1 << REG_DST) |
                                                    (2 << ALU_OP));
  localparam logic [31:0] LW_INSTR  = 32'h8D2A_FFFC;
  localparam logic [31:0] ADD_INSTR = 32'h014B_6020;

  always #5 clk = ~clk;

  id_ex_stage dut (
    .clk          (clk),
    .reset        (reset),
    .if_id_instr  (if_id_instr),
    .if_id_pc4    (if_id_pc4),
    .ctrl_in      (ctrl_in),
    .rd1          (rd1),
    .rd2          (rd2),
    .flush        (flush),
    .ex_stall     (ex_stall),
    .ex_ctrl      (ex_ctrl),
    .ex_valid     (ex_valid),
    .ex_a         (ex_a),
    .ex_b         (ex_b),
    .ex_imm       (ex_imm),
    .ex_rs        (ex_rs),
    .ex_rt        (ex_rt),
    .ex_rd        (ex_rd),
    .ex_pc4       (ex_pc4),
    .hazard_stall (hazard_stall),
    .bubble_count (bubble_count)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    tests_run++;
    if (observed !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
    end
  endtask

  function automatic bit modelLoadUse();
    return m_valid && m_ctrl[MEM_READ] && (m_rt != 5'd0) &&
           ((m_rt == if_id_instr[25:21]) || (m_rt == if_id_instr[20:16]));
  endfunction

  function automatic bit modelHazardStall();
    return modelLoadUse() && !flush && !ex_stall;
  endfunction

  task automatic clearModel();
    m_ctrl  = '0;
    m_valid = 1'b0;
    m_a     = '0;
    m_b     = '0;
    m_imm   = '0;
    m_pc4   = '0;
    m_rs    = '0;
    m_rt    = '0;
    m_rd    = '0;
  endtask

  task automatic checkAll(input string tag);
    checkOutput({tag, ".ex_ctrl"},  32'(ex_ctrl),  32'(m_ctrl));
    checkOutput({tag, ".ex_valid"}, 32'(ex_valid), 32'(m_valid));
    checkOutput({tag, ".ex_a"},     ex_a,          m_a);
    checkOutput({tag, ".ex_b"},     ex_b,          m_b);
    checkOutput({tag, ".ex_imm"},   ex_imm,        m_imm);
    checkOutput({tag, ".ex_rs"},    32'(ex_rs),    32'(m_rs));
    checkOutput({tag, ".ex_rt"},    32'(ex_rt),    32'(m_rt));
    checkOutput({tag, ".ex_rd"},    32'(ex_rd),    32'(m_rd));
    checkOutput({tag, ".ex_pc4"},   ex_pc4,        m_pc4);
    checkOutput({tag, ".count"},    bubble_count,  32'(m_count));
  endtask

  // Drive one cycle's inputs just after a falling edge and check the
  // combinational stall against the model.
  task automatic applyStimulus(input logic rst, input logic [31:0] instr,
                               input logic [31:0] pc4, input logic [CTRL_W-1:0] ctrl,
                               input logic [31:0] a, input logic [31:0] b,
                               input logic fl, input logic st);
    reset       = rst;
    if_id_instr = instr;
    if_id_pc4   = pc4;
    ctrl_in     = ctrl;
    rd1         = a;
    rd2         = b;
    flush       = fl;
    ex_stall    = st;
    #1;
    checkOutput("hazard_stall", 32'(hazard_stall), 32'(modelHazardStall()));
  endtask

  // Clock the DUT, step the model by the stage's per-edge rules, and compare
  // every registered output at the following falling edge.
  task automatic advanceClock(input string tag);
    bit lu_now;
    lu_now = modelLoadUse();
    @(posedge clk);
    if (reset) begin
      clearModel();
      m_count = 0;
    end else if (ex_stall) begin
      // everything holds
    end else if (flush || lu_now) begin
      clearModel();
      if (m_count < 64'hFFFF_FFFF) m_count = m_count + 1;
    end else begin
      m_ctrl  = ctrl_in;
      m_valid = 1'b1;
      m_a     = rd1;
      m_b     = rd2;
      m_imm   = 32'($signed(if_id_instr[15:0]));
      m_rs    = if_id_instr[25:21];
      m_rt    = if_id_instr[20:16];
      m_rd    = if_id_instr[15:11];
      m_pc4   = if_id_pc4;
    end
    @(negedge clk);
    checkAll(tag);
  endtask

  initial begin
    logic [31:0] instr;
    logic [CTRL_W-1:0] ctrl;
    clearModel();
    m_count = 0;
    reset = 1'b1; if_id_instr = '0; if_id_pc4 = '0; ctrl_in = '0;
    rd1 = '0; rd2 = '0; flush = 1'b0; ex_stall = 1'b0;
    @(negedge clk);

    // Reset with arbitrary inputs for two cycles
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1'b1, $urandom, $urandom, CTRL_W'($urandom), $urandom, $urandom,
                    1'($urandom), 1'($urandom));
      advanceClock("reset");
    end
    checkOutput("reset.valid", 32'(ex_valid), 32'd0);
    checkOutput("reset.count", bubble_count, 32'd0);
    checkOutput("reset.stall", 32'(hazard_stall), 32'd0);

    // Normal load: lw $10,-4($9)
    applyStimulus(1'b0, LW_INSTR, 32'h0000_0104, CTRL_LW, 32'd100, 32'd7, 1'b0, 1'b0);
    advanceClock("lw");
    checkOutput("lw.ex_a", ex_a, 32'd100);
    checkOutput("lw.ex_imm", ex_imm, 32'hFFFF_FFFC);
    checkOutput("lw.ex_rt", 32'(ex_rt), 32'd10);
    checkOutput("lw.ex_valid", 32'(ex_valid), 32'd1);

    // Load-use: add $12,$10,$11 behind the lw
    applyStimulus(1'b0, ADD_INSTR, 32'h0000_0108, CTRL_ADD, 32'd55, 32'd66, 1'b0, 1'b0);
    checkOutput("lu.stall", 32'(hazard_stall), 32'd1);
    advanceClock("lu_bubble");
    checkOutput("lu.bubble_valid", 32'(ex_valid), 32'd0);
    checkOutput("lu.bubble_ctrl", 32'(ex_ctrl), 32'd0);
    checkOutput("lu.count", bubble_count, 32'd1);
    applyStimulus(1'b0, ADD_INSTR, 32'h0000_0108, CTRL_ADD, 32'd55, 32'd66, 1'b0, 1'b0);
    checkOutput("lu.stall_released", 32'(hazard_stall), 32'd0);
    advanceClock("lu_add");
    checkOutput("lu.add_rs", 32'(ex_rs), 32'd10);
    checkOutput("lu.add_valid", 32'(ex_valid), 32'd1);

    // Flush coinciding with a load-use
    applyStimulus(1'b0, LW_INSTR, 32'h0000_0200, CTRL_LW, 32'd100, 32'd7, 1'b0, 1'b0);
    advanceClock("lw2");
    applyStimulus(1'b0, ADD_INSTR, 32'h0000_0204, CTRL_ADD, 32'd1, 32'd2, 1'b1, 1'b0);
    checkOutput("flush_lu.stall", 32'(hazard_stall), 32'd0);
    advanceClock("flush_lu");
    checkOutput("flush_lu.valid", 32'(ex_valid), 32'd0);
    checkOutput("flush_lu.count", bubble_count, 32'd2);

    // External freeze with flush pending for three cycles
    applyStimulus(1'b0, LW_INSTR, 32'h0000_0300, CTRL_LW, 32'd100, 32'd7, 1'b0, 1'b0);
    advanceClock("lw3");
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, ADD_INSTR, 32'h0000_0304, CTRL_ADD, $urandom, $urandom, 1'b1, 1'b1);
      checkOutput("stall.hazard", 32'(hazard_stall), 32'd0);
      advanceClock("stall");
      checkOutput("stall.valid", 32'(ex_valid), 32'd1);
      checkOutput("stall.ex_a", ex_a, 32'd100);
      checkOutput("stall.count", bubble_count, 32'd2);
    end
    applyStimulus(1'b0, ADD_INSTR, 32'h0000_0304, CTRL_ADD, 32'd0, 32'd0, 1'b1, 1'b0);
    advanceClock("stall_release");
    checkOutput("stall_release.valid", 32'(ex_valid), 32'd0);
    checkOutput("stall_release.count", bubble_count, 32'd3);

    // Saturation: preload the counter just below its ceiling
    force dut.bubble_count_q = 32'hFFFF_FFFE;
    #1;
    release dut.bubble_count_q;
    m_count = 64'hFFFF_FFFE;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, $urandom, $urandom, CTRL_W'($urandom), $urandom, $urandom, 1'b1, 1'b0);
      advanceClock("sat");
      checkOutput("sat.count", bubble_count, 32'hFFFF_FFFF);
    end

    // Reset arriving while a load-use is pending
    applyStimulus(1'b0, LW_INSTR, 32'h0000_0400, CTRL_LW, 32'd100, 32'd7, 1'b0, 1'b0);
    advanceClock("lw4");
    applyStimulus(1'b1, ADD_INSTR, 32'h0000_0404, CTRL_ADD, 32'd1, 32'd2, 1'b0, 1'b0);
    advanceClock("reset_mid_hazard");
    checkOutput("reset_mid.valid", 32'(ex_valid), 32'd0);
    checkOutput("reset_mid.count", bubble_count, 32'd0);

    // Random traffic with narrow register numbers so hazards are frequent
    for (int i = 0; i < 400; i++) begin
      instr = $urandom;
      instr[25:21] = 5'($urandom_range(0, 3));
      instr[20:16] = 5'($urandom_range(0, 3));
      ctrl = CTRL_W'($urandom);
      ctrl[MEM_READ] = ($urandom_range(0, 1) == 1);
      applyStimulus($urandom_range(0, 39) == 0, instr, $urandom, ctrl, $urandom, $urandom,
                    $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0);
      advanceClock("rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
